// File: rtl/bus_pkg.sv
// bus_pkg: shared system-bus tag encodings and responder state type.
package bus_pkg;
    localparam int SYSBUS_READ     = 1;
    localparam int SYSBUS_WRITE    = 0;
    localparam int SYSBUS_MEMORY   = 1;
    localparam int SYSBUS_READ_TAG = (SYSBUS_READ << 12) | (SYSBUS_MEMORY << 8);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/bus_line_ram.sv
// bus_line_ram: word store with one synchronous write port and one combinational read port.
module bus_line_ram #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/bus_mem_responder.sv
// bus_mem_responder: answers memory-read tags with an 8-beat line after a fixed latency,
// with a backdoor word-load port and a sticky flag for dropped requests.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int MEM_LINES      = 256,
    parameter int RESP_LATENCY   = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              main_bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0]         main_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]          main_bus_reqtag,
    output logic                              main_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0]         main_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]          main_bus_resptag,
    input  logic                              main_bus_respack,
    input  logic                              load_en,
    input  logic [$clog2(MEM_LINES*8)-1:0]    load_addr,
    input  logic [BUS_DATA_WIDTH-1:0]         load_data,
    output logic                              busy,
    output logic                              drop_err
);
    localparam int LW = $clog2(MEM_LINES);
    localparam int AW = $clog2(MEM_LINES * 8);

    state_t                   state, next_state;
    logic [LW-1:0]            line, next_line;
    logic [2:0]               beat, next_beat;
    logic [3:0]               cnt, next_cnt;
    logic [BUS_TAG_WIDTH-1:0] tag, next_tag;
    logic                     next_drop;
    logic [BUS_DATA_WIDTH-1:0] rd_data;
    logic                     unused_req;

    // only the line index bits of the address matter; the rest wrap away
    assign unused_req = ^main_bus_req;

    bus_line_ram #(.WIDTH(BUS_DATA_WIDTH), .DEPTH(MEM_LINES * 8)) u_ram (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr ({line, beat}),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            line     <= '0;
            beat     <= '0;
            cnt      <= '0;
            tag      <= '0;
            drop_err <= 1'b0;
        end else begin
            state    <= next_state;
            line     <= next_line;
            beat     <= next_beat;
            cnt      <= next_cnt;
            tag      <= next_tag;
            drop_err <= next_drop;
        end
    end

    always_comb begin
        next_state = state;
        next_line  = line;
        next_beat  = beat;
        next_cnt   = cnt;
        next_tag   = tag;
        next_drop  = drop_err;
        case (state)
            IDLE: if (main_bus_reqcyc) begin
                if (main_bus_reqtag == BUS_TAG_WIDTH'(SYSBUS_READ_TAG)) begin
                    next_line  = main_bus_req[6 +: LW];
                    next_tag   = main_bus_reqtag;
                    next_cnt   = '0;
                    next_beat  = '0;
                    next_state = WAIT;
                end else begin
                    next_drop = 1'b1;
                end
            end
            WAIT: begin
                next_drop = drop_err | main_bus_reqcyc;
                if (cnt == 4'(RESP_LATENCY - 1)) begin
                    next_state = RESP;
                    next_beat  = '0;
                end else begin
                    next_cnt = cnt + 4'd1;
                end
            end
            RESP: begin
                next_drop = drop_err | main_bus_reqcyc;
                if (main_bus_respack) begin
                    next_beat  = beat + 3'd1;
                    next_state = (beat == 3'd7) ? IDLE : RESP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy             = state != IDLE;
    assign main_bus_respcyc = state == RESP;
    assign main_bus_resp    = main_bus_respcyc ? rd_data : '0;
    assign main_bus_resptag = main_bus_respcyc ? tag : '0;
endmodule

// File: tb/tb_bus_mem_responder.sv
// tb_bus_mem_responder: directed scenario checks for the memory-read responder.
module tb_bus_mem_responder;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int AW = 11;
    localparam logic [TW-1:0] RD_TAG = 13'h1100;
    localparam logic [TW-1:0] WR_TAG = 13'h0100;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          reqcyc = 1'b0;
    logic [DW-1:0] req = '0;
    logic [TW-1:0] reqtag = '0;
    logic          respcyc;
    logic [DW-1:0] resp;
    logic [TW-1:0] resptag;
    logic          respack = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          busy;
    logic          drop_err;
    int            total = 0;
    int            bad = 0;

    bus_mem_responder #(
        .BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .MEM_LINES(256), .RESP_LATENCY(4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .main_bus_reqcyc  (reqcyc),
        .main_bus_req     (req),
        .main_bus_reqtag  (reqtag),
        .main_bus_respcyc (respcyc),
        .main_bus_resp    (resp),
        .main_bus_resptag (resptag),
        .main_bus_respack (respack),
        .load_en          (load_en),
        .load_addr        (load_addr),
        .load_data        (load_data),
        .busy             (busy),
        .drop_err         (drop_err)
    );

    always #5 clk = ~clk;

    task automatic preload();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            load_en = 1'b1;
            load_addr = AW'(3 * 8 + i);
            load_data = DW'(64'h30 + i);
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // issues a read and checks exact latency, beat order and tag; stalls 3 cycles on stall_beat
    task automatic run_read(input logic [DW-1:0] addr, input int stall_beat, input string name);
        int b;
        int stall;
        @(negedge clk);
        reqcyc = 1'b1; req = addr; reqtag = RD_TAG; respack = 1'b1;
        @(negedge clk);
        reqcyc = 1'b0; req = '0; reqtag = '0;
        total++;
        if (busy !== 1'b1 || respcyc !== 1'b0) begin
            bad++;
            $display("FAIL %s_accept: busy=%b respcyc=%b want busy=1 respcyc=0", name, busy, respcyc);
        end
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            total++;
            if (respcyc !== 1'b0) begin
                bad++;
                $display("FAIL %s_wait%0d: respcyc=%b want 0", name, w, respcyc);
            end
        end
        b = 0;
        stall = 0;
        while (b < 8) begin
            @(negedge clk);
            total++;
            if (respcyc !== 1'b1 || resp !== DW'(64'h30 + b) || resptag !== RD_TAG) begin
                bad++;
                $display("FAIL %s_beat%0d: respcyc=%b resp=%h tag=%h want 1 %h %h",
                         name, b, respcyc, resp, resptag, DW'(64'h30 + b), RD_TAG);
            end
            if (b == stall_beat && stall < 3) begin
                respack = 1'b0;
                stall++;
            end else begin
                respack = 1'b1;
                b++;
            end
        end
        @(negedge clk);
        respack = 1'b0;
        total++;
        if (respcyc !== 1'b0 || busy !== 1'b0 || resp !== '0 || resptag !== '0) begin
            bad++;
            $display("FAIL %s_end: respcyc=%b busy=%b resp=%h tag=%h want all 0",
                     name, respcyc, busy, resp, resptag);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (respcyc !== 1'b0 || resp !== '0 || resptag !== '0 || busy !== 1'b0 || drop_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: respcyc=%b resp=%h tag=%h busy=%b drop=%b want all 0",
                     respcyc, resp, resptag, busy, drop_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_basic_read();
        run_read(64'hC0, -1, "basic");
    endtask

    task automatic test_backpressure();
        run_read(64'hC0, 2, "backpressure");
    endtask

    task automatic test_wrap();
        run_read(64'h4000C0, -1, "wrap");
        run_read(64'hFFFF_FFFF_FFFF_C0FF & 64'hFFFF_FFFF_FFFF_C0FF, -1, "wrap_low");
    endtask

    task automatic test_drop();
        int n;
        @(negedge clk);
        reqcyc = 1'b1; req = 64'hC0; reqtag = WR_TAG;
        @(negedge clk);
        reqcyc = 1'b0; reqtag = '0;
        total++;
        if (drop_err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL bad_tag: drop=%b busy=%b want drop=1 busy=0", drop_err, busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (respcyc !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL bad_tag_idle%0d: respcyc=%b busy=%b want 0 0", i, respcyc, busy);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (drop_err !== 1'b0) begin
            bad++;
            $display("FAIL drop_clear: drop=%b want 0", drop_err);
        end
        reset = 1'b1;
        @(negedge clk);
        reqcyc = 1'b1; req = 64'hC0; reqtag = RD_TAG; respack = 1'b1;
        @(negedge clk);
        req = 64'h100;
        @(negedge clk);
        reqcyc = 1'b0; req = '0; reqtag = '0;
        total++;
        if (drop_err !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_drop: drop=%b busy=%b want 1 1", drop_err, busy);
        end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (respcyc === 1'b1) begin
                total++;
                if (resp !== DW'(64'h30 + n)) begin
                    bad++;
                    $display("FAIL busy_drop_beat%0d: resp=%h want %h", n, resp, DW'(64'h30 + n));
                end
                n++;
            end
        end
        respack = 1'b0;
        total++;
        if (n !== 8) begin
            bad++;
            $display("FAIL busy_drop_count: beats=%0d want 8", n);
        end
    endtask

    task automatic test_reset_mid_resp();
        int k;
        @(negedge clk);
        reqcyc = 1'b1; req = 64'hC0; reqtag = RD_TAG; respack = 1'b1;
        @(negedge clk);
        reqcyc = 1'b0; req = '0; reqtag = '0;
        k = 0;
        while (!(respcyc === 1'b1 && resp === DW'(64'h34)) && k < 20) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= 20) begin
            bad++;
            $display("FAIL mid_reset_reach: beat 4 not seen within 20 cycles, want seen");
        end
        reset = 1'b0;
        #1;
        total++;
        if (respcyc !== 1'b0 || busy !== 1'b0 || resp !== '0 || resptag !== '0 || drop_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: respcyc=%b busy=%b resp=%h tag=%h drop=%b want all 0",
                     respcyc, busy, resp, resptag, drop_err);
        end
        @(negedge clk);
        reset = 1'b1;
        respack = 1'b0;
        run_read(64'hC0, -1, "after_reset");
    endtask

    initial begin
        test_reset();
        preload();
        test_basic_read();
        test_backpressure();
        test_drop();
        test_wrap();
        test_reset_mid_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, width of one bus beat.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, width of request/response tags.
REQ-003 SHALL have parameter MEM_LINES, default 256, number of 64-byte lines stored; power of two.
REQ-004 SHALL have parameter RESP_LATENCY, default 4, idle cycles between request acceptance and first beat; range 1..15.
REQ-005 SHALL have a single clock, clk (input, 1), with all state updated on its rising edge.
REQ-006 SHALL have reset (input, 1), an asynchronous, active-low reset.
REQ-007 SHALL have main_bus_reqcyc (input, 1), request valid.
REQ-008 SHALL have main_bus_req (input, BUS_DATA_WIDTH), request byte address.
REQ-009 SHALL have main_bus_reqtag (input, BUS_TAG_WIDTH), request tag.
REQ-010 SHALL have main_bus_respcyc (output, 1), response beat valid.
REQ-011 SHALL have main_bus_resp (output, BUS_DATA_WIDTH), response beat data.
REQ-012 SHALL have main_bus_resptag (output, BUS_TAG_WIDTH), response tag.
REQ-013 SHALL have main_bus_respack (input, 1), initiator acceptance of the current beat.
REQ-014 SHALL have load_en (input, 1), load_addr (input, clog2(MEM_LINES*8)), and load_data (input, BUS_DATA_WIDTH), forming a backdoor word-write port.
REQ-015 SHALL have busy (output, 1), asserted whenever state is not IDLE.
REQ-016 SHALL have drop_err (output, 1), a sticky flag set when a request is dropped.

Function
REQ-017 SHALL implement the states IDLE, WAIT and RESP.
REQ-018 In IDLE, reqcyc=1 with reqtag == (SYSBUS_READ<<12 | SYSBUS_MEMORY<<8) SHALL latch line index = req[6 +: clog2(MEM_LINES)] and the tag, clear the latency counter, and move to WAIT; request address bits above the index and below bit 6 SHALL be ignored (wrap modulo MEM_LINES).
REQ-019 In IDLE, reqcyc=1 with any other tag SHALL leave the state in IDLE and set drop_err.
REQ-020 reqcyc=1 in WAIT or RESP, including the cycle of the final ack, SHALL be ignored and SHALL set drop_err.
REQ-021 WAIT SHALL last exactly RESP_LATENCY cycles, then move to RESP with beat index 0.
REQ-022 In RESP, respcyc SHALL be 1, resp SHALL equal word[line][beat], and resptag SHALL equal the latched tag.
REQ-023 A beat SHALL advance only in a cycle with respack=1 sampled; respack=0 SHALL hold the beat index and data stable.
REQ-024 Beats SHALL be delivered in order 0..7; an ack on beat 7 SHALL return the state to IDLE, with respcyc=0 on the next cycle.
REQ-025 Request-to-first-beat latency SHALL be RESP_LATENCY+1 cycles; a new request SHALL be acceptable on the first IDLE cycle after the final ack.
REQ-026 load_en SHALL write load_data to word load_addr in any state; a beat presented in the cycle after a load to that word SHALL show the new data.
REQ-027 Outside RESP, respcyc, resp and resptag SHALL be 0.

Reset
REQ-028 Asserting reset (reset=0) SHALL force IDLE, respcyc=0, resp=0, resptag=0, busy=0, drop_err=0, and beat and latency counters to 0, including mid-operation.
REQ-029 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-030 SYSBUS_READ, SYSBUS_MEMORY, the read-tag constant and the state enum SHALL reside in shared package bus_pkg.
REQ-031 Storage SHALL be a sub-module, bus_line_ram, with one write port and one combinational read port of MEM_LINES*8 words.

Verification
REQ-032 The bench SHALL cover basic read: preload line 3 words with 0x30..0x37, send a read request with address 0xC0, and hold respack=1; beats 0x30..0x37 SHALL appear starting 5 cycles after acceptance, and respcyc SHALL drop after beat 7.
REQ-033 The bench SHALL cover backpressure: during the same read, hold respack=0 for 3 cycles on beat 2; 0x32 SHALL be held stable for 3 cycles with no skipped or duplicated beats.
REQ-034 The bench SHALL cover bad tag and busy drop: a write-tag request in IDLE and a read request during WAIT SHALL produce no response and drop_err=1.
REQ-035 The bench SHALL cover wrap: with MEM_LINES=256, a read of address 0x4000C0 SHALL return line 3's data.
REQ-036 The bench SHALL cover reset mid-RESP: assert reset=0 at beat 4; respcyc=0 and IDLE SHALL follow immediately, and a following read of line 3 SHALL return the unchanged 0x30..0x37.
